// File: rtl/store_buffer.sv
// Posted-write store buffer: lane-aligns stores, queues them in a circular FIFO and drains one per memory handshake.
// Define STORE_BUFFER_FWD_EN to build store-to-load forwarding; otherwise fwd_mask/fwd_data are tied to zero.
module store_buffer #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  st_valid,
  output logic                  st_ready,
  input  logic [ADDR_WIDTH-1:0] st_addr,
  input  logic [DATA_WIDTH-1:0] st_data,
  input  logic                  WE0,
  input  logic                  WE1,
  input  logic                  WE2,
  input  logic                  WE3,
  output logic                  misalign,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  empty,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  output logic [3:0]            fwd_mask,
  output logic [DATA_WIDTH-1:0] fwd_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int WA_W  = ADDR_WIDTH - 2;
  localparam logic [PTR_W:0]   FULL    = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);

  function automatic logic [6:0] lane_shift(input logic [3:0] we, input logic [1:0] off);
    lane_shift = {3'b000, we} << off;
  endfunction

  logic [WA_W-1:0]       addr_q [DEPTH];
  logic [3:0]            we_q   [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];

  logic [PTR_W-1:0] head, tail;
  logic [PTR_W:0]   count;
  logic             misalign_p1;

  logic [3:0]            we_raw_p0;
  logic [6:0]            we_sh_p0;
  logic [DATA_WIDTH-1:0] data_sh_p0;
  logic                  drop_p0, acc_p0, push_p0, pop_p0;

  // Stage p0: align incoming store and decide push/pop
  assign we_raw_p0  = {WE3, WE2, WE1, WE0};
  assign we_sh_p0   = lane_shift(we_raw_p0, st_addr[1:0]);
  assign data_sh_p0 = st_data << {st_addr[1:0], 3'b000};
  assign drop_p0    = (we_raw_p0 == 4'b0000) || (we_sh_p0[6:4] != 3'b000);
  assign acc_p0     = st_valid && st_ready;
  assign push_p0    = acc_p0 && !drop_p0;
  assign pop_p0     = mem_valid && mem_ready;

  // Stage p1: FIFO control state and misalign pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      misalign_p1 <= 1'b0;
    end else begin
      if (push_p0) tail <= tail + PTR_ONE;
      if (pop_p0)  head <= head + PTR_ONE;
      case ({push_p0, pop_p0})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      misalign_p1 <= acc_p0 && drop_p0;
    end
  end

  // Entry payload carries no reset; validity comes only from count
  always_ff @(posedge clk) begin
    if (push_p0) begin
      addr_q[tail] <= st_addr[ADDR_WIDTH-1:2];
      we_q[tail]   <= we_sh_p0[3:0];
      data_q[tail] <= data_sh_p0;
    end
  end

  assign st_ready  = (count != FULL);
  assign mem_valid = (count != '0);
  assign empty     = (count == '0);
  assign misalign  = misalign_p1;
  assign mem_addr  = mem_valid ? {addr_q[head], 2'b00} : '0;
  assign mem_we    = mem_valid ? we_q[head] : 4'b0000;
  assign mem_wdata = mem_valid ? data_q[head] : '0;

`ifdef STORE_BUFFER_FWD_EN
  logic [PTR_W-1:0] fidx;
  logic             unused_ld;
  assign unused_ld = ^ld_addr[1:0];

  // Walk oldest to youngest so younger matches overwrite older bytes
  always_comb begin
    fwd_mask = 4'b0000;
    fwd_data = '0;
    fidx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fidx = head + PTR_W'(k);
      if (((PTR_W+1)'(k) < count) && (addr_q[fidx] == ld_addr[ADDR_WIDTH-1:2])) begin
        for (int i = 0; i < 4; i++) begin
          if (we_q[fidx][i]) begin
            fwd_mask[i]        = 1'b1;
            fwd_data[8*i +: 8] = data_q[fidx][8*i +: 8];
          end
        end
      end
    end
  end
`else
  logic unused_ld;
  assign unused_ld = ^ld_addr;
  assign fwd_mask  = 4'b0000;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: a scoreboard queue holds expected memory writes, popped on each drain handshake.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        st_valid = 1'b0;
  logic        st_ready;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic        WE0 = 1'b0, WE1 = 1'b0, WE2 = 1'b0, WE3 = 1'b0;
  logic        misalign;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr;
  logic [3:0]  mem_we;
  logic [31:0] mem_wdata;
  logic        empty;
  logic [31:0] ld_addr = '0;
  logic [3:0]  fwd_mask;
  logic [31:0] fwd_data;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [3:0]  w;
    logic [31:0] d;
  } ent_t;
  ent_t sb[$];

  store_buffer #(.DEPTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
    .WE0(WE0), .WE1(WE1), .WE2(WE2), .WE3(WE3),
    .misalign(misalign),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata),
    .empty(empty), .ld_addr(ld_addr), .fwd_mask(fwd_mask), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare the head against the scoreboard if a pop is about to happen, then advance one cycle.
  task automatic tick();
    ent_t e;
    if (mem_valid && mem_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_write", 32'(mem_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_addr", mem_addr, e.a);
        chk("sb_we", 32'(mem_we), 32'(e.w));
        chk("sb_data", mem_wdata, e.d);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    logic [3:0]  ew;
    logic [31:0] ed;
    logic        drop, acc;
    int          off;
    off  = int'(a[1:0]);
    ew   = '0;
    ed   = '0;
    drop = (w == 4'b0000);
    for (int i = 0; i < 4; i++) begin
      if (w[i]) begin
        if (i + off > 3) drop = 1'b1;
        else begin
          ew[i+off]          = 1'b1;
          ed[8*(i+off) +: 8] = d[8*i +: 8];
        end
      end
    end
    acc = st_ready;
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    {WE3, WE2, WE1, WE0} = w;
    if (acc && !drop) sb.push_back('{a: {a[31:2], 2'b00}, w: ew, d: ed});
    tick();
    st_valid = 1'b0;
    chk("misalign", 32'(misalign), 32'(acc && drop));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_st_ready"}, 32'(st_ready), 32'd1);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_mem_valid"}, 32'(mem_valid), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_misalign"}, 32'(misalign), 32'd0);
    chk({tag, "_fwd_mask"}, 32'(fwd_mask), 32'd0);
    chk({tag, "_fwd_data"}, fwd_data, 32'd0);
  endtask

  task automatic drain(input string tag);
    mem_ready = 1'b1;
    for (int i = 0; i < 20 && !empty; i++) tick();
    chk({tag, "_drained"}, 32'(empty), 32'd1);
    chk({tag, "_sb_left"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    rst_n = 1'b1;
    tick();

    // Byte store at 0x103
    mem_ready = 1'b1;
    store(32'h103, 32'h0000_00AB, 4'b0001);
    chk("sb_mem_valid", 32'(mem_valid), 32'd1);
    chk("sb_mem_addr", mem_addr, 32'h100);
    chk("sb_mem_we", 32'(mem_we), 32'b1000);
    chk("sb_mem_wdata", mem_wdata, 32'hAB00_0000);
    tick();
    chk("sb_empty_after", 32'(empty), 32'd1);

    // Fill with four words while memory stalls
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      store(32'(4 * i), 32'hA000_0000 + 32'(i), 4'b1111);
      chk("fill_st_ready", 32'(st_ready), (i == 3) ? 32'd0 : 32'd1);
    end
    tick();
    chk("hold_addr", mem_addr, 32'h0);
    chk("hold_we", 32'(mem_we), 32'hF);
    tick();
    chk("hold_data", mem_wdata, 32'hA000_0000);
    mem_ready = 1'b1;
    chk("full_popcycle_st_ready", 32'(st_ready), 32'd0);
    tick();
    chk("after_pop_st_ready", 32'(st_ready), 32'd1);
    drain("fill");

    // Dropped stores
    store(32'h3, 32'h0000_BEEF, 4'b0011);
    chk("drop_sh_empty", 32'(empty), 32'd1);
    tick();
    chk("drop_pulse_once", 32'(misalign), 32'd0);
    store(32'h2, 32'hDEAD_BEEF, 4'b1111);
    chk("drop_sw_empty", 32'(empty), 32'd1);
    store(32'h0, 32'h1234_5678, 4'b0000);
    chk("drop_zero_empty", 32'(empty), 32'd1);
    tick();
    chk("drop_end_misalign", 32'(misalign), 32'd0);

    // Full buffer with concurrent push and pop every cycle
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) store(32'h40 + 32'(4 * i), 32'hB000_0000 + 32'(i), 4'b1111);
    mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      store(32'h80 + 32'(4 * i), 32'hC000_0000 + 32'(i), 4'b1111);
      if (i > 0) chk("steady_sb_depth", 32'(sb.size()), 32'd3);
      chk("steady_st_ready", 32'(st_ready), 32'd1);
      chk("steady_mem_valid", 32'(mem_valid), 32'd1);
    end
    drain("steady");

    // Forwarding
    mem_ready = 1'b0;
    store(32'h20, 32'h1122_3344, 4'b1111);
    store(32'h21, 32'h0000_00FF, 4'b0001);
    ld_addr = 32'h20;
    #1;
`ifdef STORE_BUFFER_FWD_EN
    chk("fwd_mask", 32'(fwd_mask), 32'hF);
    chk("fwd_data", fwd_data, 32'h1122_FF44);
    ld_addr = 32'h24;
    #1;
    chk("fwd_miss_mask", 32'(fwd_mask), 32'h0);
    chk("fwd_miss_data", fwd_data, 32'h0);
`else
    chk("nofwd_mask", 32'(fwd_mask), 32'h0);
    chk("nofwd_data", fwd_data, 32'h0);
`endif
    ld_addr = 32'h0;

    // Asynchronous reset with three entries queued
    store(32'h30, 32'h5555_AAAA, 4'b1111);
    chk("pre_rst_mem_valid", 32'(mem_valid), 32'd1);
    chk("pre_rst_sb_depth", 32'(sb.size()), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    sb.delete();
    tick();
    tick();
    rst_n = 1'b1;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_mem_valid", 32'(mem_valid), 32'd0);
    end
    store(32'h50, 32'h1234_5678, 4'b1111);
    chk("post_rst_new_valid", 32'(mem_valid), 32'd1);
    drain("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the memory stage and the byte-lane data memory. Accepts a store with the per-lane write enables WE0..WE3 produced by the write-enable decoder, aligns data and lanes to the byte address, and queues entries in a small FIFO. Drains one entry per accepted memory handshake, so a slow memory does not stall the pipeline until the buffer fills. Optional store-to-load forwarding lets loads see queued stores.

## Interface
Parameters:
- DEPTH, 4: number of entries; power of two, 2..16.
- ADDR_WIDTH, 32: byte address width.
- DATA_WIDTH, 32: fixed at 32; four byte lanes.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- st_valid  in  1  store request from memory stage.
- st_ready  out  1  buffer can accept a store this cycle.
- st_addr  in  ADDR_WIDTH  store byte address.
- st_data  in  32  store data, LSB-justified.
- WE0, WE1, WE2, WE3  in  1 each  lane enables from the decoder, unshifted.
- misalign  out  1  one-cycle pulse: accepted store was dropped as misaligned or empty.
- mem_valid  out  1  head entry presented to memory.
- mem_ready  in  1  memory accepts head entry this cycle.
- mem_addr  out  ADDR_WIDTH  word-aligned address {addr[ADDR_WIDTH-1:2], 2'b00}.
- mem_we  out  4  byte-lane enables, bit i = byte i.
- mem_wdata  out  32  lane-aligned data.
- empty  out  1  no queued entries.
- ld_addr  in  ADDR_WIDTH  load address, used for forwarding.
- fwd_mask  out  4  lanes supplied by the buffer.
- fwd_data  out  32  forwarded bytes; lanes outside fwd_mask are 0.

## Operation
- Enqueue on st_valid && st_ready. Lane shift by off = st_addr[1:0]: we = {WE3,WE2,WE1,WE0} << off, truncated to 4 bits; data = st_data << (8*off).
- Drop rule: an accepted store is not enqueued if the unshifted enables are all zero, or if any enabled lane shifts past bit 3. Examples: sh at off 3, sw at off != 0. A dropped store pulses misalign the next cycle and leaves the FIFO untouched.
- FIFO: circular, with head and tail pointers of log2(DEPTH) bits that wrap naturally, plus a count of log2(DEPTH)+1 bits. st_ready = (count != DEPTH). A push while full cannot happen because st_ready is low.
- Drain: mem_valid = (count != 0). mem_addr, mem_we and mem_wdata come from the head entry and are all zero when empty. Pop on mem_valid && mem_ready. Outputs are held stable while mem_valid && !mem_ready.
- Simultaneous push and pop: count unchanged, both pointers advance. When full, a pop does not raise st_ready in the same cycle; st_ready rises the next cycle.
- Ordering: strict FIFO. Memory sees stores in program order.

## Timing
- Reset values:
  - count, head and tail = 0
  - st_ready = 1, empty = 1
  - mem_valid = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0
  - misalign = 0, fwd_mask = 0, fwd_data = 0
- Reset asserted mid-operation discards every queued entry immediately. There is no partial drain.
- Latency: a store accepted in cycle N appears on the memory port in cycle N+1 if the buffer was empty.
- st_ready, mem_valid and empty are registered-state decodes with no combinational path from mem_ready.
- Forwarding outputs are combinational from ld_addr and the current contents. A store accepted in cycle N is visible to forwarding from cycle N+1.

## Configuration
- STORE_BUFFER_FWD_EN defined:
  - Every valid entry, including the head being drained, is compared on address bits [ADDR_WIDTH-1:2] against ld_addr.
  - For each lane, the youngest matching entry with that lane enabled supplies the byte and sets fwd_mask[i].
- STORE_BUFFER_FWD_EN undefined: fwd_mask and fwd_data are tied to 0, no comparators are built, and ld_addr is unused.

## Test plan
- sb, addr 0x103, data 0xAB, WE=0001, memory ready → next cycle mem_addr 0x100, mem_we 1000, mem_wdata 0xAB000000, then empty=1.
- Four sw at 0x0, 0x4, 0x8, 0xC with mem_ready=0 → st_ready low after the 4th. Raise mem_ready: stores drain in order, one per cycle, and st_ready returns the cycle after the first pop.
- sh at addr 0x3 (WE=0011) → misalign pulses once, nothing enqueued, empty stays 1. Same for sw at 0x2 and for WE=0000.
- Full buffer with st_valid=1 and mem_ready=1 every cycle → one push and one pop per cycle after steady state, count constant, no loss.
- Forwarding on: queue sw 0x11223344 at 0x20, then sb 0xFF at 0x21; ld_addr 0x20 → fwd_mask 1111, fwd_data 0x1122FF44. Forwarding off → fwd_mask 0.
- Assert rst_n low with 3 entries queued and mem_valid high → all outputs return to reset values asynchronously. After release, mem_valid stays 0 until a new store.
